// File: rtl/gam_pattern_feeder.sv
//==============================================================================
// Module   : gam_pattern_feeder
// Purpose  : Transmitter side of the Memory_Layer learning handshake. Holds a
//            loadable table of training node vectors (CLASS_COUNT classes x
//            NODE_COUNT nodes) and streams one (x, c) pair per rising READY
//            event, class-major / node-minor. learning_done rises with the
//            final pair and is held until the next start or reset.
// Ports    : clk, reset (sync, active-low)
//            load_en/load_class/load_node/load_data : table write port
//            num_classes/num_nodes/start            : stream configuration
//            ready_wait                             : 1=READY, 0=WAIT
//            x, c, x_valid, learning_done, busy     : stream outputs
//            zero_skips                             : skipped zero entries
// Options  : `define GAM_FEEDER_ZERO_SKIP_EN to skip all-zero table entries
//            without spending a READY event on them.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module gam_pattern_feeder #(
    parameter int NODE_W      = 32,
    parameter int CLASS_COUNT = 4,
    parameter int NODE_COUNT  = 5,
    parameter int CW          = $clog2(CLASS_COUNT + 1),
    parameter int NW          = $clog2(NODE_COUNT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [CW-1:0]     load_class,
    input  logic [NW-1:0]     load_node,
    input  logic [NODE_W-1:0] load_data,
    input  logic [CW-1:0]     num_classes,
    input  logic [NW-1:0]     num_nodes,
    input  logic              start,
    input  logic              ready_wait,
    output logic [NODE_W-1:0] x,
    output logic [CW-1:0]     c,
    output logic              x_valid,
    output logic              learning_done,
    output logic              busy,
    output logic [7:0]        zero_skips
);

    // Zero-based table index widths (exactly wide enough for each dimension)
    localparam int c_ciw = (CLASS_COUNT > 1) ? $clog2(CLASS_COUNT) : 1;
    localparam int c_niw = (NODE_COUNT  > 1) ? $clog2(NODE_COUNT)  : 1;
    localparam logic [CW-1:0] c_cmax = CW'(CLASS_COUNT);
    localparam logic [NW-1:0] c_nmax = NW'(NODE_COUNT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_ISSUE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [NODE_W-1:0] r_table [CLASS_COUNT][NODE_COUNT];

    logic [CW-1:0]     r_class_cnt;
    logic [NW-1:0]     r_node_cnt;
    logic [CW-1:0]     r_nc;
    logic [NW-1:0]     r_nn;
    logic              r_ready_q;
    logic [NODE_W-1:0] r_x;
    logic [CW-1:0]     r_c;
    logic              r_x_valid;
    logic              r_done;

    logic              w_busy;
    logic              w_start_ok;
    logic              w_ready_evt;
    logic              w_last;
    logic              w_skip;
    logic              w_wr_ok;
    logic [c_ciw-1:0]  w_ld_ci;
    logic [c_niw-1:0]  w_ld_ni;
    logic [c_ciw-1:0]  w_rd_ci;
    logic [c_niw-1:0]  w_rd_ni;
    logic [NODE_W-1:0] w_entry;
    logic [CW-1:0]     w_nc_clamp;
    logic [NW-1:0]     w_nn_clamp;

    assign w_busy      = (r_state == S_ARM) || (r_state == S_ISSUE);
    assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_ready_evt = ready_wait && !r_ready_q;
    assign w_last      = (r_class_cnt == r_nc) && (r_node_cnt == r_nn);

    // Stream length is clamped into 1..max so the counters always terminate
    assign w_nc_clamp = (num_classes == '0)   ? CW'(1) :
                        (num_classes > c_cmax) ? c_cmax : num_classes;
    assign w_nn_clamp = (num_nodes == '0)     ? NW'(1) :
                        (num_nodes > c_nmax)   ? c_nmax : num_nodes;

    // ---------------------------------------------------------------- table
    assign w_wr_ok = load_en && !w_busy &&
                     (load_class != '0) && (load_class <= c_cmax) &&
                     (load_node  != '0) && (load_node  <= c_nmax);
    assign w_ld_ci = c_ciw'(load_class - CW'(1));
    assign w_ld_ni = c_niw'(load_node  - NW'(1));
    assign w_rd_ci = c_ciw'(r_class_cnt - CW'(1));
    assign w_rd_ni = c_niw'(r_node_cnt  - NW'(1));
    assign w_entry = r_table[w_rd_ci][w_rd_ni];

    // Table contents survive reset so a stream can be replayed after reset
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_table[w_ld_ci][w_ld_ni] <= load_data;
        end
    end

`ifdef GAM_FEEDER_ZERO_SKIP_EN
    logic [7:0] r_zero_skips;

    assign w_skip = (w_entry == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_zero_skips <= 8'd0;
        end else if ((r_state == S_ISSUE) && w_skip && (r_zero_skips != 8'hFF)) begin
            r_zero_skips <= r_zero_skips + 8'd1;
        end
    end

    assign zero_skips = r_zero_skips;
`else
    assign w_skip     = 1'b0;
    assign zero_skips = 8'd0;
`endif

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_ARM;
            S_ARM:   if (w_ready_evt) w_state_nxt = S_ISSUE;
            S_ISSUE: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end else if (w_skip) begin
                    // Skipped entry: evaluate the next one without a new READY
                    w_state_nxt = S_ISSUE;
                end else begin
                    w_state_nxt = S_ARM;
                end
            end
            S_DONE:  if (start) w_state_nxt = S_ARM;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_class_cnt <= CW'(1);
            r_node_cnt  <= NW'(1);
            r_nc        <= CW'(1);
            r_nn        <= NW'(1);
            r_ready_q   <= 1'b0;
            r_x         <= '0;
            r_c         <= '0;
            r_x_valid   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_x_valid <= 1'b0;
            // Clearing the edge detector on start lets a READY that is
            // already high count as the first event.
            r_ready_q <= w_start_ok ? 1'b0 : ready_wait;

            if (w_start_ok) begin
                r_nc        <= w_nc_clamp;
                r_nn        <= w_nn_clamp;
                r_class_cnt <= CW'(1);
                r_node_cnt  <= NW'(1);
                r_done      <= 1'b0;
            end else if (r_state == S_ISSUE) begin
                if (!w_skip) begin
                    r_x       <= w_entry;
                    r_c       <= r_class_cnt;
                    r_x_valid <= 1'b1;
                end
                if (w_last) begin
                    r_done <= 1'b1;
                end else if (r_node_cnt == r_nn) begin
                    r_node_cnt  <= NW'(1);
                    r_class_cnt <= r_class_cnt + CW'(1);
                end else begin
                    r_node_cnt  <= r_node_cnt + NW'(1);
                end
            end
        end
    end

    assign x             = r_x;
    assign c             = r_c;
    assign x_valid       = r_x_valid;
    assign learning_done = r_done;
    assign busy          = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_gam_pattern_feeder.sv
//==============================================================================
// Module   : tb_gam_pattern_feeder
// Purpose  : Scoreboard bench for gam_pattern_feeder. Stimulus pushes the
//            expected {x, c, learning_done} for each pair; a monitor pops and
//            compares on every x_valid pulse.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_gam_pattern_feeder;

    localparam int NODE_W = 32;
    localparam int CW     = 3;
    localparam int NW     = 3;

    localparam logic [31:0] A1 = 32'hA1A1_0001;
    localparam logic [31:0] A2 = 32'hA2A2_0002;
    localparam logic [31:0] B1 = 32'hB1B1_0001;
    localparam logic [31:0] B2 = 32'hB2B2_0002;
    localparam logic [31:0] C1 = 32'hC1C1_0001;
    localparam logic [31:0] D1 = 32'hD1D1_0001;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_en;
    logic [CW-1:0]     load_class;
    logic [NW-1:0]     load_node;
    logic [NODE_W-1:0] load_data;
    logic [CW-1:0]     num_classes;
    logic [NW-1:0]     num_nodes;
    logic              start;
    logic              ready_wait;
    logic [NODE_W-1:0] x;
    logic [CW-1:0]     c;
    logic              x_valid;
    logic              learning_done;
    logic              busy;
    logic [7:0]        zero_skips;

    int n_tests = 0;
    int n_fail  = 0;

    logic [NODE_W+CW:0] exp_q [$];

    gam_pattern_feeder dut (
        .clk           (clk),
        .reset         (reset),
        .load_en       (load_en),
        .load_class    (load_class),
        .load_node     (load_node),
        .load_data     (load_data),
        .num_classes   (num_classes),
        .num_nodes     (num_nodes),
        .start         (start),
        .ready_wait    (ready_wait),
        .x             (x),
        .c             (c),
        .x_valid       (x_valid),
        .learning_done (learning_done),
        .busy          (busy),
        .zero_skips    (zero_skips)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Monitor: every x_valid pulse must match the next scoreboard entry
    always @(negedge clk) begin
        if (reset && x_valid) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pair: got x=%h c=%0d done=%0b, none expected",
                         x, c, learning_done);
            end else begin
                logic [NODE_W+CW:0] e;
                e = exp_q.pop_front();
                if ({x, c, learning_done} !== e) begin
                    n_fail++;
                    $display("FAIL pair: got x=%h c=%0d done=%0b, expected x=%h c=%0d done=%0b",
                             x, c, learning_done, e[NODE_W+CW:CW+1], e[CW:1], e[0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] ex, input int ec, input bit ed);
        exp_q.push_back({ex, CW'(ec), ed});
    endtask

    task automatic wr(input int cls, input int nd, input logic [31:0] d);
        load_en    = 1'b1;
        load_class = CW'(cls);
        load_node  = NW'(nd);
        load_data  = d;
        tick();
        load_en    = 1'b0;
    endtask

    task automatic go(input int ncl, input int nnd);
        num_classes = CW'(ncl);
        num_nodes   = NW'(nnd);
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            ready_wait = 1'b1;
            tick();
            tick();
            ready_wait = 1'b0;
            tick();
            tick();
        end
    endtask

    task automatic check_drained(input string name);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d expected pairs never issued, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        reset = 1'b0; load_en = 1'b0; load_class = '0; load_node = '0;
        load_data = '0; num_classes = '0; num_nodes = '0; start = 1'b0;
        ready_wait = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();

        check("reset_x", x, 32'h0);
        check("reset_c", 32'(c), 32'h0);
        check("reset_valid", 32'(x_valid), 32'h0);
        check("reset_done", 32'(learning_done), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_zero_skips", 32'(zero_skips), 32'h0);

        // 1: single class, four nodes
        wr(1, 1, 32'h0003); wr(1, 2, 32'h0400); wr(1, 3, 32'h070005); wr(1, 4, 32'h1111);
        push(32'h0003, 1, 0); push(32'h0400, 1, 0); push(32'h070005, 1, 0); push(32'h1111, 1, 1);
        go(1, 4);
        check("t1_busy", 32'(busy), 32'h1);
        pulses(4);
        check("t1_busy_after", 32'(busy), 32'h0);
        check("t1_done_held", 32'(learning_done), 32'h1);
        check("t1_x_hold", x, 32'h1111);
        check_drained("t1_drain");

        // 2: two classes x two nodes, class-major order
        wr(1, 1, A1); wr(1, 2, A2); wr(2, 1, B1); wr(2, 2, B2);
        push(A1, 1, 0); push(A2, 1, 0); push(B1, 2, 0); push(B2, 2, 1);
        go(2, 2);
        pulses(4);
        check_drained("t2_drain");

        // 3: READY already high at start, then held high
        ready_wait = 1'b1;
        tick(); tick();
        push(A1, 1, 0); push(A2, 1, 1);
        go(1, 2);
        tick();
        check("t3_no_valid_yet", 32'(x_valid), 32'h0);
        check("t3_busy", 32'(busy), 32'h1);
        tick();
        check("t3_first_valid", 32'(x_valid), 32'h1);
        check("t3_first_x", x, A1);
        for (int i = 0; i < 10; i++) tick();
        check("t3_one_issue_per_event", 32'(exp_q.size()), 32'h1);
        ready_wait = 1'b0;
        tick(); tick();
        pulses(1);
        check_drained("t3_drain");

        // 4: reset mid-stream, restart, write while busy is dropped
        push(A1, 1, 0); push(A2, 1, 0);
        go(2, 2);
        pulses(2);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("t4_reset_busy", 32'(busy), 32'h0);
        check("t4_reset_x", x, 32'h0);
        check("t4_reset_done", 32'(learning_done), 32'h0);
        push(A1, 1, 0); push(A2, 1, 0); push(B1, 2, 0); push(B2, 2, 1);
        go(2, 2);
        wr(1, 1, 32'hDEAD_BEEF);
        pulses(4);
        check_drained("t4_drain");

        // 5: clamping plus out-of-range writes that must be dropped
        wr(3, 1, C1); wr(4, 1, D1);
        wr(0, 1, 32'hBAD0_0000);
        wr(5, 1, 32'hBAD0_0005);
        wr(1, 0, 32'hBAD0_0010);
        wr(1, 6, 32'hBAD0_0016);
        push(A1, 1, 0); push(B1, 2, 0); push(C1, 3, 0); push(D1, 4, 1);
        go(7, 0);
        pulses(4);
        check("t5_done", 32'(learning_done), 32'h1);
        check_drained("t5_drain");

        // 6: zero entry handling; the extra pulse lands in DONE and is ignored
        wr(1, 1, 32'h0003); wr(1, 2, 32'h0); wr(1, 3, 32'h1111);
        push(32'h0003, 1, 0);
`ifdef GAM_FEEDER_ZERO_SKIP_EN
        push(32'h1111, 1, 1);
`else
        push(32'h0, 1, 0);
        push(32'h1111, 1, 1);
`endif
        go(1, 3);
        pulses(3);
`ifdef GAM_FEEDER_ZERO_SKIP_EN
        check("t6_zero_skips", 32'(zero_skips), 32'h1);
`else
        check("t6_zero_skips", 32'(zero_skips), 32'h0);
`endif
        check("t6_done", 32'(learning_done), 32'h1);
        check("t6_busy", 32'(busy), 32'h0);
        check_drained("t6_drain");

        tick(); tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
